// File: rtl/bus_cycle_ctrl.sv
// 8085-style T1/T2/[TW]/T3 bus cycle sequencer for the multiplexed AD bus.
// Optional feature: define WAIT_TIMEOUT_EN to abort cycles stuck in TW after TIMEOUT_CYCLES.
module bus_cycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic        req_io,
  input  logic        req_fetch,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        err,
  input  logic        READY,
  output logic        ALE,
  output logic        S0,
  output logic        S1,
  output logic        IOMn,
  output logic        RDn,
  output logic        WRn,
  output logic        dbus_to_instr_reg,
  output logic [7:0]  haddress,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3} state_t;
  typedef enum logic [1:0] {K_READ, K_WRITE, K_FETCH} kind_t;

  function automatic logic [1:0] status_of(input kind_t k);
    case (k)
      K_FETCH: return 2'b11;
      K_READ:  return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  state_t      state, state_d;
  kind_t       kind, kind_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  status, status_d;
  logic        ale_d, iomn_d, rdn_d, wrn_d, dbus_d, ad_oe_d, busy_d, ack_d;
  logic [7:0]  haddress_d, ad_out_d, rdata_d;
  logic        go_t3;

`ifdef WAIT_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
  logic [CW-1:0] wait_cnt, wait_cnt_d;
  logic          timed_out, timed_out_d;
  logic          err_d;
`else
  assign err = 1'b0;
`endif

  assign S1 = status[1];
  assign S0 = status[0];

  // NOTE: every signal driven here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d    = state;
    kind_d     = kind;
    wdata_d    = wdata_q;
    status_d   = status;
    ale_d      = ALE;
    iomn_d     = IOMn;
    rdn_d      = RDn;
    wrn_d      = WRn;
    dbus_d     = dbus_to_instr_reg;
    ad_oe_d    = ad_oe;
    haddress_d = haddress;
    ad_out_d   = ad_out;
    rdata_d    = rdata;
    ack_d      = 1'b0;
    go_t3      = 1'b0;
`ifdef WAIT_TIMEOUT_EN
    wait_cnt_d  = wait_cnt;
    timed_out_d = timed_out;
    err_d       = 1'b0;
`endif

    unique case (state)
      S_IDLE: begin
        if (req) begin
          kind_d     = req_fetch ? K_FETCH : (req_we ? K_WRITE : K_READ);
          wdata_d    = req_wdata;
          state_d    = S_T1;
          ale_d      = 1'b1;
          haddress_d = req_addr[15:8];
          ad_out_d   = req_addr[7:0];
          ad_oe_d    = 1'b1;
          status_d   = status_of(kind_d);
          iomn_d     = req_fetch ? 1'b0 : req_io;
        end
      end
      S_T1: begin
        state_d = S_T2;
        ale_d   = 1'b0;
`ifdef WAIT_TIMEOUT_EN
        wait_cnt_d  = '0;
        timed_out_d = 1'b0;
`endif
        if (kind == K_WRITE) begin
          ad_out_d = wdata_q;
          wrn_d    = 1'b0;
        end else begin
          ad_oe_d = 1'b0;
          rdn_d   = 1'b0;
        end
      end
      S_T2: begin
        if (READY) go_t3 = 1'b1;
        else       state_d = S_TW;
      end
      S_TW: begin
        if (READY) go_t3 = 1'b1;
`ifdef WAIT_TIMEOUT_EN
        // The count holds completed TW states; the last one allowed forces T3.
        else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          go_t3       = 1'b1;
          timed_out_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
`endif
      end
      S_T3: begin
        state_d  = S_IDLE;
        rdn_d    = 1'b1;
        wrn_d    = 1'b1;
        ad_oe_d  = 1'b0;
        status_d = 2'b00;
        dbus_d   = 1'b0;
        ack_d    = 1'b1;
`ifdef WAIT_TIMEOUT_EN
        err_d = timed_out;
        if (kind != K_WRITE) rdata_d = timed_out ? 8'hFF : ad_in;
`else
        if (kind != K_WRITE) rdata_d = ad_in;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (go_t3) begin
      state_d = S_T3;
      dbus_d  = (kind == K_FETCH);
    end
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      kind              <= K_READ;
      wdata_q           <= '0;
      status            <= 2'b00;
      ALE               <= 1'b0;
      IOMn              <= 1'b0;
      RDn               <= 1'b1;
      WRn               <= 1'b1;
      dbus_to_instr_reg <= 1'b0;
      ad_oe             <= 1'b0;
      haddress          <= '0;
      ad_out            <= '0;
      rdata             <= '0;
      busy              <= 1'b0;
      ack               <= 1'b0;
    end else begin
      state             <= state_d;
      kind              <= kind_d;
      wdata_q           <= wdata_d;
      status            <= status_d;
      ALE               <= ale_d;
      IOMn              <= iomn_d;
      RDn               <= rdn_d;
      WRn               <= wrn_d;
      dbus_to_instr_reg <= dbus_d;
      ad_oe             <= ad_oe_d;
      haddress          <= haddress_d;
      ad_out            <= ad_out_d;
      rdata             <= rdata_d;
      busy              <= busy_d;
      ack               <= ack_d;
    end
  end

`ifdef WAIT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      wait_cnt  <= wait_cnt_d;
      timed_out <= timed_out_d;
      err       <= err_d;
    end
  end
`endif

endmodule
